uart_rx_sampler: RTL

UART_RX_SAMPLER -- requirements
Module: uart_rx_sampler

---
 rtl/uart_rx_sampler.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - oversampling 8N1 UART receiver
//
// Purpose:
//   Receives 8N1 frames (LSB first, idle high) from an asynchronous serial
//   line that is oversampled SAMPLES_PER_BIT times per bit by smp_clk.
//   Optional macro RX_MAJORITY_VOTE_EN: each bit is the 2-of-3 majority of
//   the line around the bit centre and all decisions move one cycle later.
//
// Ports:
//   smp_clk   in   sampling clock, all logic on its rising edge
//   reset     in   synchronous, active-high reset
//   uart_rx   in   asynchronous serial input
//   rx_data   out  [7:0] last correctly framed byte, held between frames
//   rx_status out  one-cycle pulse when rx_data updates
//   rx_err    out  one-cycle pulse on framing error (stop bit low)

module uart_rx_sampler #(
  parameter int SAMPLES_PER_BIT = 16
) (
  input  logic       smp_clk,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       rx_err
);

  localparam int CW = $clog2(SAMPLES_PER_BIT);
  localparam logic [CW-1:0] MID  = CW'(SAMPLES_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(SAMPLES_PER_BIT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic          r_sync1;
  logic          r_sync2;
  logic [1:0]    r_warm;
  logic          r_armed;
  logic [2:0]    r_state;
  logic [CW-1:0] r_ctr;
  logic [3:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_status;
  logic          r_err;

  logic          w_line;
  logic          w_sample;
  logic          w_sample_pt;

  assign w_line = r_sync2;

`ifdef RX_MAJORITY_VOTE_EN
  localparam logic [CW-1:0] MID_M1 = MID - CW'(1);
  localparam logic [CW-1:0] MID_P1 = MID + CW'(1);

  // line captured at mid-1 and mid; the third vote is the live line at mid+1
  logic [1:0] r_vote;

  always_ff @(posedge smp_clk) begin
    if (reset) begin
      r_vote <= 2'b11;
    end else begin
      if (r_ctr == MID_M1) r_vote[0] <= w_line;
      if (r_ctr == MID)    r_vote[1] <= w_line;
    end
  end

  assign w_sample    = (r_vote[0] & r_vote[1]) | (r_vote[0] & w_line) | (r_vote[1] & w_line);
  assign w_sample_pt = (r_ctr == MID_P1);
`else
  assign w_sample    = w_line;
  assign w_sample_pt = (r_ctr == MID);
`endif

  always_ff @(posedge smp_clk) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_warm    <= 2'b00;
      r_armed   <= 1'b0;
      r_state   <= S_IDLE;
      r_ctr     <= '0;
      r_bit_idx <= 4'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_status  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_sync1  <= uart_rx;
      r_sync2  <= r_sync1;
      // The synchronizer is forced high by reset, so the line is trusted only
      // once both flops hold real input. A start is accepted only after a
      // real high has been seen, so a frame cut by reset is not resumed.
      r_warm   <= {r_warm[0], 1'b1};
      if (r_warm[1] && w_line) r_armed <= 1'b1;
      r_status <= 1'b0;
      r_err    <= 1'b0;

      // Bit counter; in cycle t0 it is 0, so START is entered with 1.
      if (r_ctr == LAST) begin
        r_ctr     <= '0;
        r_bit_idx <= r_bit_idx + 4'd1;
      end else begin
        r_ctr     <= r_ctr + CW'(1);
      end

      case (r_state)
        S_IDLE: begin
          r_ctr     <= '0;
          r_bit_idx <= 4'd0;
          if (!w_line && r_armed) begin
            r_state <= S_START;
            r_ctr   <= CW'(1);
          end
        end
        S_START: begin
          if (w_sample_pt) begin
            if (w_sample) begin
              r_state   <= S_IDLE;
              r_ctr     <= '0;
              r_bit_idx <= 4'd0;
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_sample_pt) begin
            r_shift <= {w_sample, r_shift[7:1]};
            if (r_bit_idx == 4'd8) r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_sample_pt) begin
            r_ctr     <= '0;
            r_bit_idx <= 4'd0;
            if (w_sample) begin
              r_data   <= r_shift;
              r_status <= 1'b1;
              r_state  <= S_IDLE;
            end else begin
              r_err    <= 1'b1;
              r_state  <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          r_ctr     <= '0;
          r_bit_idx <= 4'd0;
          if (w_line) r_state <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          r_ctr     <= '0;
          r_bit_idx <= 4'd0;
        end
      endcase
    end
  end

  assign rx_data   = r_data;
  assign rx_status = r_status;
  assign rx_err    = r_err;

endmodule
